// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounces N push buttons on a slow tick, turns holds into
// PRESS/LONG/REPEAT/RELEASE events and queues them in a small valid/ready FIFO.
module button_event_ctrl #(
  parameter int N_BTN = 4,
  parameter int SAMPLE_DIV = 250000,
  parameter int LONG_TICKS = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_btn,
  output logic [1:0]       evt_type,
  output logic [N_BTN-1:0] btn_level,
  output logic             overflow
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int HMAX = LONG_TICKS > REPEAT_TICKS ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW = $clog2(HMAX + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [1:0] PRESS = 2'd0, LONG = 2'd1, REPEAT = 2'd2, RELEASE = 2'd3;
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_e;

  logic [N_BTN-1:0] s1_q, s1_d, s2_q, s2_d, level_q, level_d, pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic adv_q, adv_d, ovf_q, ovf_d;
  logic [N_BTN-1:0][3:0] win_q, win_d;
  logic [N_BTN-1:0][HW-1:0] hold_q, hold_d;
  logic [N_BTN-1:0][1:0] ptype_q, ptype_d;
  state_e state_q [N_BTN];
  state_e state_d [N_BTN];
  logic [FIFO_DEPTH-1:0][4:0] mem_q, mem_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [NW-1:0] fcnt_q, fcnt_d;
  logic tick, push, pop, accept;
  logic [2:0] sel;
  logic [1:0] sel_type;
  logic [HW-1:0] hold_inc;
  logic [N_BTN-1:0] raise;
  logic [N_BTN-1:0][1:0] rtype;

  assign evt_valid = fcnt_q != '0;
  assign evt_btn   = evt_valid ? mem_q[rp_q][4:2] : 3'd0;
  assign evt_type  = evt_valid ? mem_q[rp_q][1:0] : 2'd0;
  assign btn_level = level_q;
  assign overflow  = ovf_q;

  always_comb begin
    tick = cnt_q == CW'(SAMPLE_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    adv_d = tick;
    s1_d = btn_raw;
    s2_d = s1_q;
    win_d = win_q;
    level_d = level_q;
    hold_d = hold_q;
    state_d = state_q;
    pend_d = pend_q;
    ptype_d = ptype_q;
    ovf_d = ovf_q;
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    raise = '0;
    rtype = '0;
    hold_inc = '0;
    // FSMs step on the clk after the tick, when the freshly shifted window is visible
    for (int i = 0; i < N_BTN; i++) begin
      win_d[i] = tick ? {s2_q[i], win_q[i][3:1]} : win_q[i];
      hold_inc = hold_q[i] + 1'b1;
      if (adv_q && !level_q[i] && win_q[i] == 4'hf) begin
        level_d[i] = 1'b1;
        state_d[i] = PRESSED;
        hold_d[i] = '0;
        raise[i] = 1'b1;
        rtype[i] = PRESS;
      end else if (adv_q && level_q[i] && win_q[i] == 4'h0) begin
        level_d[i] = 1'b0;
        state_d[i] = IDLE;
        raise[i] = 1'b1;
        rtype[i] = RELEASE;
      end else if (adv_q && state_q[i] != IDLE) begin
        hold_d[i] = hold_inc;
        if (state_q[i] == PRESSED && hold_inc == HW'(LONG_TICKS)) begin
          state_d[i] = HELD;
          hold_d[i] = '0;
          raise[i] = 1'b1;
          rtype[i] = LONG;
        end else if (state_q[i] == HELD && hold_inc == HW'(REPEAT_TICKS)) begin
          hold_d[i] = '0;
          raise[i] = 1'b1;
          rtype[i] = REPEAT;
        end
      end
    end
    push = 1'b0;
    sel = '0;
    sel_type = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push = 1'b1;
        sel = 3'(i);
        sel_type = ptype_q[i];
      end
    end
    pop = evt_valid & evt_ready;
    accept = push && (fcnt_q != NW'(FIFO_DEPTH) || pop);
    // a pending entry being pushed this clk is not counted as overwritten
    for (int i = 0; i < N_BTN; i++) begin
      if (push && sel == 3'(i)) pend_d[i] = 1'b0;
      if (raise[i]) begin
        if (pend_d[i]) ovf_d = 1'b1;
        pend_d[i] = 1'b1;
        ptype_d[i] = rtype[i];
      end
    end
    if (push && !accept) ovf_d = 1'b1;
    if (accept) begin
      mem_d[wp_q] = {sel, sel_type};
      wp_d = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    fcnt_d = fcnt_q + NW'(accept) - NW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
      adv_q <= 1'b0;
      win_q <= '0;
      level_q <= '0;
      hold_q <= '0;
      state_q <= '{default: IDLE};
      pend_q <= '0;
      ptype_q <= '0;
      ovf_q <= 1'b0;
      mem_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      fcnt_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      cnt_q <= cnt_d;
      adv_q <= adv_d;
      win_q <= win_d;
      level_q <= level_d;
      hold_q <= hold_d;
      state_q <= state_d;
      pend_q <= pend_d;
      ptype_q <= ptype_d;
      ovf_q <= ovf_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      fcnt_q <= fcnt_d;
    end
  end
endmodule

// File: tb/tb_button_event_ctrl.sv
// tb_button_event_ctrl: scoreboard bench; a tick-level behavioural model predicts
// events, FIFO occupancy and overflow, and a monitor checks each popped event.
module tb_button_event_ctrl;
  localparam int N = 4, SD = 4, LT = 3, RT = 2, FD = 4;
  logic clk = 0, reset = 0, evt_ready = 0;
  logic [N-1:0] btn_raw = '0;
  logic evt_valid, overflow;
  logic [2:0] evt_btn;
  logic [1:0] evt_type;
  logic [N-1:0] btn_level;

  button_event_ctrl #(.N_BTN(N), .SAMPLE_DIV(SD), .LONG_TICKS(LT), .REPEAT_TICKS(RT),
    .FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .btn_raw(btn_raw), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_btn(evt_btn), .evt_type(evt_type), .btn_level(btn_level),
    .overflow(overflow));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc, occ, n_raise = 0;
  int ones [N], zeros [N], t [N];
  bit lvl [N];
  bit m_ovf, seen_valid;
  logic [N-1:0] hist [4];
  int pend [$];
  int exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: samples are the raw levels seen 3 clks before each FSM step; events
  // follow from run lengths and ticks-since-press; one pending event moves per clk.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; occ = 0; m_ovf = 0;
      pend.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) begin
        ones[i] = 0; zeros[i] = 4; t[i] = 0; lvl[i] = 0;
      end
      for (int i = 0; i < 4; i++) hist[i] = '0;
    end else begin
      cyc++;
      if (occ > 0 && evt_ready) occ--;
      if (pend.size() > 0) begin
        int e;
        e = pend.pop_front();
        if (occ < FD) begin
          occ++;
          exp_q.push_back(e);
        end else m_ovf = 1;
      end
      if (cyc % 4 == 1 && cyc >= 5) begin
        logic [N-1:0] s;
        s = hist[2];
        for (int i = 0; i < N; i++) begin
          int ty;
          ty = -1;
          if (s[i]) begin ones[i]++; zeros[i] = 0; end
          else begin zeros[i]++; ones[i] = 0; end
          if (!lvl[i] && ones[i] >= 4) begin lvl[i] = 1; t[i] = 0; ty = 0; end
          else if (lvl[i] && zeros[i] >= 4) begin lvl[i] = 0; ty = 3; end
          else if (lvl[i]) begin
            t[i]++;
            if (t[i] == LT) ty = 1;
            else if (t[i] > LT && (t[i] - LT) % RT == 0) ty = 2;
          end
          if (ty >= 0) begin
            pend.push_back(i * 4 + ty);
            n_raise++;
          end
        end
      end
      hist[cyc % 4] = btn_raw;
    end
  end

  always @(negedge clk) begin
    #1;
    if (reset) begin
      logic [N-1:0] lv;
      for (int i = 0; i < N; i++) lv[i] = lvl[i];
      check("status{valid,level,ovf}", {evt_valid, btn_level, overflow},
            {exp_q.size() != 0, lv, m_ovf});
      if (evt_valid) seen_valid = 1;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("evt_unexpected", {evt_btn, evt_type}, -1);
        else check("evt{btn,type}", {evt_btn, evt_type}, exp_q.pop_front());
      end
    end
  end

  task automatic wait_raise(input int target);
    int k;
    k = 0;
    while (n_raise < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (n_raise < target) check("raise_timeout", n_raise, target);
  endtask

  task automatic drain();
    int k;
    k = 0;
    evt_ready = 1;
    repeat (40) @(negedge clk);
    while ((exp_q.size() > 0 || pend.size() > 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", evt_valid, 0);
  endtask

  task automatic do_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_outputs", {evt_valid, evt_btn, evt_type, btn_level, overflow}, 0);
    reset = 1;
    @(negedge clk);
    check("exit_reset_outputs", {evt_valid, evt_btn, evt_type, btn_level, overflow}, 0);
    evt_ready = 1;
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      btn_raw[0] = ((k / 3) % 2) == 0;
      @(negedge clk);
    end
    check("bounce_quiet", seen_valid, 0);
    base = n_raise;
    btn_raw[0] = 1;
    wait_raise(base + 1);
    repeat (3) @(negedge clk);
    check("bounce_level0", btn_level[0], 1);
    btn_raw[0] = 0;
    drain();

    btn_raw[1] = 1;
    repeat (80) @(negedge clk);
    btn_raw[1] = 0;
    drain();

    btn_raw = 4'b0101;
    repeat (30) @(negedge clk);
    check("arb_ovf", overflow, 0);
    btn_raw = '0;
    drain();

    evt_ready = 0;
    base = n_raise;
    btn_raw[3] = 1;
    wait_raise(base + 5);
    repeat (3) @(negedge clk);
    check("full_ovf", overflow, 1);
    check("full_valid", evt_valid, 1);
    btn_raw[3] = 0;
    drain();

    do_reset();
    evt_ready = 0;
    base = n_raise;
    btn_raw[3] = 1;
    wait_raise(base + 4);
    wait_raise(base + 5);
    evt_ready = 1;
    @(negedge clk);
    evt_ready = 0;
    repeat (2) @(negedge clk);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_valid", evt_valid, 1);
    evt_ready = 1;
    btn_raw[3] = 0;
    drain();

    base = n_raise;
    btn_raw[0] = 1;
    wait_raise(base + 2);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 0;
    repeat (3) @(posedge clk);
    #1 check("midreset_outputs", {evt_valid, evt_btn, evt_type, btn_level, overflow}, 0);
    @(negedge clk);
    reset = 1;
    base = n_raise;
    wait_raise(base + 1);
    btn_raw[0] = 0;
    drain();

    for (int k = 0; k < 3000; k++) begin
      evt_ready = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 23) == 0) btn_raw[i] = ~btn_raw[i];
      @(negedge clk);
    end
    btn_raw = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
